// File: rtl/xbar_out_credit_stage.sv
// xbar_out_credit_stage
//   Registered output stage behind the router crossbar. Forwards the P
//   switched flits and their write strobes to the output links one cycle
//   later and keeps, per output VC, a downstream credit counter and an
//   ownership (packet in flight) state for the VC/switch allocators.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   flit_in_all       P*Fw  crossbar flits, port p at [(p+1)*Fw-1 : p*Fw]
//   flit_in_wr_all    P     per-port write strobes
//   credit_in_all     P*V   credit return pulses, bit p*V+v
//   flit_out_all      P*Fw  registered flits
//   flit_out_wr_all   P     registered write strobes
//   credit_avb_all    P*V   credit counter of (p,v) non-zero
//   ovc_busy_all      P*V   (p,v) owned by a packet in flight
//   credit_err_all    P     sticky credit underflow/overflow per port
module xbar_out_credit_stage #(
    parameter int V  = 4,
    parameter int P  = 5,
    parameter int Fw = 36,
    parameter int B  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [P*Fw-1:0]   flit_in_all,
    input  logic [P-1:0]      flit_in_wr_all,
    input  logic [P*V-1:0]    credit_in_all,
    output logic [P*Fw-1:0]   flit_out_all,
    output logic [P-1:0]      flit_out_wr_all,
    output logic [P*V-1:0]    credit_avb_all,
    output logic [P*V-1:0]    ovc_busy_all,
    output logic [P-1:0]      credit_err_all
);

    localparam int Cw = $clog2(B + 1);
    localparam logic [Cw-1:0] CNT_MAX = Cw'(B);

    typedef enum logic {
        OVC_IDLE = 1'b0,
        OVC_BUSY = 1'b1
    } ovc_state_e;

    logic [P*Fw-1:0] flit_out_q, flit_out_d;
    logic [P-1:0]    flit_wr_q, flit_wr_d;
    logic [Cw-1:0]   cnt_q [P][V];
    logic [Cw-1:0]   cnt_d [P][V];
    ovc_state_e      ovc_state_q [P][V];
    ovc_state_e      ovc_state_d [P][V];
    logic [P-1:0]    err_q, err_d;

    always_comb begin
        flit_out_d = flit_in_all;
        flit_wr_d  = flit_in_wr_all;
        err_d      = err_q;
        for (int unsigned p = 0; p < P; p++) begin
            for (int unsigned v = 0; v < V; v++) begin
                logic wr_ev;
                logic cr_ev;
                logic hdr;
                logic tail;
                cnt_d[p][v]       = cnt_q[p][v];
                ovc_state_d[p][v] = ovc_state_q[p][v];
                // VC field occupies [Fw-3 : Fw-2-V]; VC v is field bit v.
                wr_ev = flit_in_wr_all[p] && flit_in_all[p*Fw + Fw - 2 - V + v];
                cr_ev = credit_in_all[p*V + v];
                hdr   = flit_in_all[p*Fw + Fw - 1];
                tail  = flit_in_all[p*Fw + Fw - 2];

                // A write and a credit in the same cycle cancel out.
                if (wr_ev && !cr_ev) begin
                    if (cnt_q[p][v] == '0) begin
                        err_d[p] = 1'b1;
                    end else begin
                        cnt_d[p][v] = cnt_q[p][v] - 1'b1;
                    end
                end else if (cr_ev && !wr_ev) begin
                    if (cnt_q[p][v] == CNT_MAX) begin
                        err_d[p] = 1'b1;
                    end else begin
                        cnt_d[p][v] = cnt_q[p][v] + 1'b1;
                    end
                end

                if (wr_ev) begin
                    unique case (ovc_state_q[p][v])
                        OVC_IDLE: if (hdr && !tail) ovc_state_d[p][v] = OVC_BUSY;
                        OVC_BUSY: if (tail)         ovc_state_d[p][v] = OVC_IDLE;
                        default:                    ovc_state_d[p][v] = OVC_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_out_q <= '0;
            flit_wr_q  <= '0;
            err_q      <= '0;
            for (int unsigned p = 0; p < P; p++) begin
                for (int unsigned v = 0; v < V; v++) begin
                    cnt_q[p][v]       <= CNT_MAX;
                    ovc_state_q[p][v] <= OVC_IDLE;
                end
            end
        end else begin
            flit_out_q <= flit_out_d;
            flit_wr_q  <= flit_wr_d;
            err_q      <= err_d;
            for (int unsigned p = 0; p < P; p++) begin
                for (int unsigned v = 0; v < V; v++) begin
                    cnt_q[p][v]       <= cnt_d[p][v];
                    ovc_state_q[p][v] <= ovc_state_d[p][v];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < P; p++) begin
            for (int unsigned v = 0; v < V; v++) begin
                credit_avb_all[p*V + v] = (cnt_q[p][v] != '0);
                ovc_busy_all[p*V + v]   = (ovc_state_q[p][v] == OVC_BUSY);
            end
        end
    end

    assign flit_out_all    = flit_out_q;
    assign flit_out_wr_all = flit_wr_q;
    assign credit_err_all  = err_q;

endmodule

// File: tb/tb_xbar_out_credit_stage.sv
// Testbench for xbar_out_credit_stage: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of credits, ownership and error flags.
module tb_xbar_out_credit_stage;

    localparam int V  = 4;
    localparam int P  = 5;
    localparam int Fw = 36;
    localparam int B  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [P*Fw-1:0]   flit_in_all;
    logic [P-1:0]      flit_in_wr_all;
    logic [P*V-1:0]    credit_in_all;
    logic [P*Fw-1:0]   flit_out_all;
    logic [P-1:0]      flit_out_wr_all;
    logic [P*V-1:0]    credit_avb_all;
    logic [P*V-1:0]    ovc_busy_all;
    logic [P-1:0]      credit_err_all;

    xbar_out_credit_stage #(.V(V), .P(P), .Fw(Fw), .B(B)) dut (
        .clk             (clk),
        .reset           (reset),
        .flit_in_all     (flit_in_all),
        .flit_in_wr_all  (flit_in_wr_all),
        .credit_in_all   (credit_in_all),
        .flit_out_all    (flit_out_all),
        .flit_out_wr_all (flit_out_wr_all),
        .credit_avb_all  (credit_avb_all),
        .ovc_busy_all    (ovc_busy_all),
        .credit_err_all  (credit_err_all)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer credit counts, ownership bits, sticky errors.
    int              m_cnt  [P][V];
    bit              m_busy [P][V];
    bit [P-1:0]      m_err;
    logic [P*Fw-1:0] m_flit;
    logic [P-1:0]    m_wr;

    always @(posedge clk) begin
        if (reset) begin
            m_flit = '0;
            m_wr   = '0;
            m_err  = '0;
            for (int p = 0; p < P; p++)
                for (int v = 0; v < V; v++) begin
                    m_cnt[p][v]  = B;
                    m_busy[p][v] = 1'b0;
                end
        end else begin
            m_flit = flit_in_all;
            m_wr   = flit_in_wr_all;
            for (int p = 0; p < P; p++) begin
                logic [Fw-1:0] f;
                f = flit_in_all[p*Fw +: Fw];
                for (int v = 0; v < V; v++) begin
                    bit w, c;
                    w = flit_in_wr_all[p] && f[Fw-2-V+v];
                    c = credit_in_all[p*V+v];
                    if (w && !c) begin
                        if (m_cnt[p][v] == 0) m_err[p] = 1'b1;
                        else m_cnt[p][v] = m_cnt[p][v] - 1;
                    end else if (c && !w) begin
                        if (m_cnt[p][v] == B) m_err[p] = 1'b1;
                        else m_cnt[p][v] = m_cnt[p][v] + 1;
                    end
                    if (w) begin
                        if (f[Fw-2])      m_busy[p][v] = 1'b0;
                        else if (f[Fw-1]) m_busy[p][v] = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [P*V-1:0] e_avb, e_busy;
            for (int p = 0; p < P; p++)
                for (int v = 0; v < V; v++) begin
                    e_avb[p*V+v]  = (m_cnt[p][v] > 0);
                    e_busy[p*V+v] = m_busy[p][v];
                end
            chk("model_flit_out", flit_out_all, m_flit);
            chk("model_flit_wr", flit_out_wr_all, m_wr);
            chk("model_credit_avb", credit_avb_all, e_avb);
            chk("model_ovc_busy", ovc_busy_all, e_busy);
            chk("model_credit_err", credit_err_all, m_err);
        end
    end

    function automatic logic [Fw-1:0] mk_flit(input bit hdr, input bit tl, input logic [V-1:0] vcm);
        logic [Fw-1:0] f;
        f = '0;
        f[Fw-3-V:0] = (Fw-2-V)'($urandom);
        f[Fw-2-V +: V] = vcm;
        f[Fw-2] = tl;
        f[Fw-1] = hdr;
        return f;
    endfunction

    // Apply inputs, let one edge sample them, land just after the edge.
    task automatic step(input bit rst, input logic [P-1:0] wr, input logic [P*Fw-1:0] fl,
                        input logic [P*V-1:0] cr);
        reset          = rst;
        flit_in_wr_all = wr;
        flit_in_all    = fl;
        credit_in_all  = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, '0);
        step(1'b1, '0, '0, '0);
    endtask

    // Write one flit to (port, vc); returns the flit driven.
    task automatic wr1(input int p, input int v, input bit hdr, input bit tl,
                       input logic [P*V-1:0] cr, output logic [Fw-1:0] f);
        logic [P*Fw-1:0] fl;
        logic [P-1:0]    w;
        fl = '0;
        w  = '0;
        f  = mk_flit(hdr, tl, V'(1 << v));
        fl[p*Fw +: Fw] = f;
        w[p] = 1'b1;
        step(1'b0, w, fl, cr);
    endtask

    initial begin
        logic [Fw-1:0]   f;
        logic [P*Fw-1:0] fl;
        logic [P-1:0]    w;
        logic [P*V-1:0]  cr;

        reset = 1'b1;
        flit_in_all = '0;
        flit_in_wr_all = '0;
        credit_in_all = '0;

        // Reset values
        do_reset();
        chk_en = 1'b1;
        chk("rst_avb", credit_avb_all, 20'hFFFFF);
        chk("rst_wr", flit_out_wr_all, 5'h0);
        chk("rst_busy", ovc_busy_all, 20'h0);
        chk("rst_err", credit_err_all, 5'h0);

        // Credit exhaustion and return on port 2, VC1
        for (int i = 0; i < 4; i++) begin
            wr1(2, 1, i == 0, i == 3, '0, f);
            chk("p2_flit_fwd", flit_out_all[2*Fw +: Fw], f);
            chk("p2_wr_fwd", flit_out_wr_all, 5'b00100);
            chk("p2_avb9", credit_avb_all[9], (i < 3) ? 1'b1 : 1'b0);
        end
        cr = '0; cr[9] = 1'b1;
        step(1'b0, '0, '0, cr);
        chk("p2_credit_ret", credit_avb_all[9], 1'b1);
        chk("p2_err", credit_err_all, 5'h0);

        // Simultaneous write and credit on port 0, VC0
        do_reset();
        wr1(0, 0, 1'b0, 1'b0, '0, f);
        wr1(0, 0, 1'b0, 1'b0, '0, f);
        cr = '0; cr[0] = 1'b1;
        wr1(0, 0, 1'b0, 1'b0, cr, f);
        chk("sim_avb0_cnt2", credit_avb_all[0], 1'b1);
        wr1(0, 0, 1'b0, 1'b0, '0, f);
        chk("sim_avb0_cnt1", credit_avb_all[0], 1'b1);
        wr1(0, 0, 1'b0, 1'b0, '0, f);
        chk("sim_avb0_cnt0", credit_avb_all[0], 1'b0);
        chk("sim_err", credit_err_all, 5'h0);

        // Underflow on port 3, VC2
        do_reset();
        for (int i = 0; i < 4; i++) wr1(3, 2, 1'b0, 1'b0, '0, f);
        chk("uf_no_err_yet", credit_err_all, 5'h0);
        wr1(3, 2, 1'b0, 1'b0, '0, f);
        chk("uf_flit_fwd", flit_out_all[3*Fw +: Fw], f);
        chk("uf_wr_fwd", flit_out_wr_all, 5'b01000);
        chk("uf_err", credit_err_all, 5'b01000);
        idle(); idle();
        chk("uf_err_sticky", credit_err_all, 5'b01000);

        // Overflow on port 4, VC0: count must stay at 4
        do_reset();
        cr = '0; cr[16] = 1'b1;
        step(1'b0, '0, '0, cr);
        chk("of_err", credit_err_all, 5'b10000);
        for (int i = 0; i < 4; i++) begin
            wr1(4, 0, 1'b0, 1'b0, '0, f);
            chk("of_cnt_stays_b", credit_avb_all[16], (i < 3) ? 1'b1 : 1'b0);
        end

        // Ownership on port 1
        do_reset();
        wr1(1, 3, 1'b1, 1'b0, '0, f);
        chk("own_hdr", ovc_busy_all[7], 1'b1);
        wr1(1, 3, 1'b0, 1'b0, '0, f);
        chk("own_body", ovc_busy_all[7], 1'b1);
        wr1(1, 3, 1'b1, 1'b0, '0, f);
        chk("own_hdr_in_busy", ovc_busy_all[7], 1'b1);
        wr1(1, 3, 1'b0, 1'b1, '0, f);
        chk("own_tail", ovc_busy_all[7], 1'b0);
        wr1(1, 2, 1'b1, 1'b1, '0, f);
        chk("own_single", ovc_busy_all[6], 1'b0);
        idle();
        chk("own_single2", ovc_busy_all[6], 1'b0);
        chk("own_err", credit_err_all, 5'h0);

        // Reset mid-operation on port 2, VC1 (count 1, busy)
        do_reset();
        wr1(2, 1, 1'b1, 1'b0, '0, f);
        wr1(2, 1, 1'b0, 1'b0, '0, f);
        wr1(2, 1, 1'b0, 1'b0, '0, f);
        chk("mid_busy_pre", ovc_busy_all[9], 1'b1);
        fl = '0; w = 5'b00100; cr = '0; cr[9] = 1'b1;
        fl[2*Fw +: Fw] = mk_flit(1'b0, 1'b0, 4'b0010);
        step(1'b1, w, fl, cr);
        chk("mid_wr", flit_out_wr_all, 5'h0);
        chk("mid_busy", ovc_busy_all[9], 1'b0);
        chk("mid_avb", credit_avb_all, 20'hFFFFF);
        chk("mid_err", credit_err_all, 5'h0);
        for (int i = 0; i < 4; i++) begin
            wr1(2, 1, 1'b0, 1'b0, '0, f);
            chk("mid_cnt_full", credit_avb_all[9], (i < 3) ? 1'b1 : 1'b0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit rst;
            rst = ($urandom_range(0, 199) == 0);
            fl = '0;
            for (int p = 0; p < P; p++) begin
                logic [V-1:0] m;
                int k;
                k = $urandom_range(0, 9);
                if (k == 0)      m = '0;
                else if (k == 1) m = V'($urandom);
                else             m = V'(1 << $urandom_range(0, V-1));
                fl[p*Fw +: Fw] = mk_flit($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, m);
            end
            w = P'($urandom);
            for (int i = 0; i < P*V; i++) cr[i] = ($urandom_range(0, 2) == 0);
            step(rst, w, fl, cr);
        end

        idle();
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
